mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 10 +
 rtl/sat_counter.sv | 14 +
 rtl/mem_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
package mem_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   localparam int WADDR_W = 30;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)             cnt <= '0;
      else if (inc && ~&cnt)  cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data has priority; the requester owning the current cycle is masked from next-state selection.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_req,
   input  logic [31:0]            i_addr,
   output logic                   i_valid,
   output logic [31:0]            i_rdata,
   input  logic                   d_rreq,
   input  logic                   d_wreq,
   input  logic [31:0]            d_addr,
   input  logic [31:0]            d_wdata,
   input  logic [3:0]             d_wbyte,
   output logic                   d_valid,
   output logic [31:0]            d_rdata,
   output logic                   mem_read_ready,
   output logic                   mem_write_ready,
   output logic [WADDR_W-1:0]     mem_address,
   output logic [31:0]            mem_write_data,
   output logic [3:0]             mem_write_byte,
   input  logic [31:0]            mem_read_data,
   output logic [STALL_CNT_W-1:0] conflict_cnt,
   output logic                   err
);
   state_t state, state_nxt;
   logic   i_pend, d_pend, conflict;
   logic   unused_addr_lsb;

   assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

   // The granted side's request still describes its in-flight access, so it is masked.
   always_comb begin
      i_pend   = i_req && (state != GNT_I);
      d_pend   = (d_rreq || d_wreq) && (state != GNT_D);
      conflict = i_pend && d_pend;
      state_nxt = IDLE;
      if (d_pend)      state_nxt = GNT_D;
      else if (i_pend) state_nxt = GNT_I;
   end

   always_comb begin
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      mem_address     = '0;
      mem_write_data  = '0;
      mem_write_byte  = '0;
      case (state)
         GNT_I: begin
            mem_read_ready = 1'b1;
            mem_address    = i_addr[31:2];
         end
         GNT_D: begin
            mem_address     = d_addr[31:2];
            mem_write_ready = d_wreq;
            mem_read_ready  = d_rreq && !d_wreq;
            mem_write_byte  = d_wreq ? d_wbyte : 4'b0000;
            mem_write_data  = d_wdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         i_valid <= 1'b0;
         d_valid <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         i_valid <= (state == GNT_I);
         d_valid <= (state == GNT_D);
         if (d_rreq && d_wreq) err <= 1'b1;
      end
   end

   assign i_rdata = mem_read_data;
   assign d_rdata = mem_read_data;

   sat_counter #(.W(STALL_CNT_W)) u_conflict_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (conflict),
      .cnt   (conflict_cnt)
   );
endmodule
